// File: rtl/flag_unit.sv
// ALU result register with an ARM-style NZCV flag unit, one-cycle latency.
// Define FLAG_BYPASS_EN to forward next-edge flags combinationally on FlagsNext.
module flag_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ALUValid,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       FlagW,
  input  logic             CondEx,
  input  logic             Stall,
  output logic [WIDTH-1:0] ALUResult,
  output logic             ResultValid,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsNext
);

  logic             is_arith;
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  logic             n_flag, z_flag, c_flag, v_flag;
  logic             adv;
  logic             nz_we, cv_we;

  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic [1:0]       nz_q, nz_d;
  logic [1:0]       cv_q, cv_d;

  assign is_arith = ~ALUControl[1];
  assign is_sub   = ALUControl[0];

  // Subtraction reuses the adder: SrcA + ~SrcB + 1, so carry-out means no borrow.
  assign b_op = is_sub ? ~SrcB : SrcB;
  assign sum  = {1'b0, SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    result = '0;
    unique case (ALUControl)
      2'b00, 2'b01: result = sum[WIDTH-1:0];
      2'b10:        result = SrcA & SrcB;
      2'b11:        result = SrcA | SrcB;
      default:      result = '0;
    endcase
  end

  assign n_flag = result[WIDTH-1];
  assign z_flag = (result == '0);
  assign c_flag = sum[WIDTH];
  assign v_flag = (SrcA[WIDTH-1] == b_op[WIDTH-1]) & (result[WIDTH-1] != SrcA[WIDTH-1]);

  assign adv   = ~Stall;
  assign nz_we = ALUValid & CondEx & FlagW[1] & adv;
  assign cv_we = ALUValid & CondEx & FlagW[0] & is_arith & adv;

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (nz_we) nz_d = {n_flag, z_flag};
    if (cv_we) cv_d = {c_flag, v_flag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      nz_q     <= 2'b00;
      cv_q     <= 2'b00;
    end else if (adv) begin
      valid_q <= ALUValid;
      if (ALUValid) result_q <= result;
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  assign ALUResult   = result_q;
  assign ResultValid = valid_q;
  assign Flags       = {nz_q, cv_q};

`ifdef FLAG_BYPASS_EN
  assign FlagsNext = {nz_d, cv_d};
`else
  assign FlagsNext = Flags;
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Directed, table-driven bench for flag_unit (WIDTH=32) plus stall and async-reset sequences.
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ALUValid;
  logic [1:0]  ALUControl;
  logic [31:0] SrcA, SrcB;
  logic [1:0]  FlagW;
  logic        CondEx;
  logic        Stall;
  logic [31:0] ALUResult;
  logic        ResultValid;
  logic [3:0]  Flags;
  logic [3:0]  FlagsNext;

  int passed = 0;
  int total  = 0;

  flag_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUValid   (ALUValid),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .FlagW      (FlagW),
    .CondEx     (CondEx),
    .Stall      (Stall),
    .ALUResult  (ALUResult),
    .ResultValid(ResultValid),
    .Flags      (Flags),
    .FlagsNext  (FlagsNext)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  fw;
    logic        ce;
    logic        st;
    logic [31:0] res;
    logic        rv;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] fw, input logic ce,
                       input logic st);
    ALUValid = v; ALUControl = c; SrcA = a; SrcB = b; FlagW = fw; CondEx = ce; Stall = st;
  endtask

  // Apply at the current (negedge) point, clock once, sample 1 time unit after the edge.
  task automatic step(input string name, input logic [31:0] res, input logic rv,
                      input logic [3:0] fl);
`ifdef FLAG_BYPASS_EN
    #1 check({name, ".flags_next"}, {28'd0, FlagsNext}, {28'd0, fl});
`endif
    @(posedge clk);
    #1;
    check({name, ".result"}, ALUResult, res);
    check({name, ".valid"}, {31'd0, ResultValid}, {31'd0, rv});
    check({name, ".flags"}, {28'd0, Flags}, {28'd0, fl});
`ifndef FLAG_BYPASS_EN
    check({name, ".flags_next"}, {28'd0, FlagsNext}, {28'd0, fl});
`endif
    @(negedge clk);
  endtask

  initial begin
    //              v     ctrl   a             b             fw     ce    st    res           rv    fl
    vecs[0]  = '{1'b1, 2'b00, 32'h7FFFFFFF, 32'h00000001, 2'b11, 1'b1, 1'b0, 32'h80000000, 1'b1, 4'b1001};
    vecs[1]  = '{1'b1, 2'b01, 32'd5,        32'd5,        2'b11, 1'b1, 1'b0, 32'h00000000, 1'b1, 4'b0110};
    vecs[2]  = '{1'b1, 2'b01, 32'd3,        32'd5,        2'b11, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b1, 4'b1000};
    vecs[3]  = '{1'b1, 2'b01, 32'd5,        32'd5,        2'b11, 1'b1, 1'b0, 32'h00000000, 1'b1, 4'b0110};
    vecs[4]  = '{1'b1, 2'b10, 32'h000000F0, 32'h0000000F, 2'b11, 1'b1, 1'b0, 32'h00000000, 1'b1, 4'b0110};
    vecs[5]  = '{1'b1, 2'b00, 32'h7FFFFFFF, 32'h00000001, 2'b11, 1'b1, 1'b0, 32'h80000000, 1'b1, 4'b1001};
    vecs[6]  = '{1'b1, 2'b10, 32'h000000F0, 32'h0000000F, 2'b11, 1'b0, 1'b0, 32'h00000000, 1'b1, 4'b1001};
    vecs[7]  = '{1'b0, 2'b00, 32'h12345678, 32'h1,        2'b11, 1'b1, 1'b0, 32'h00000000, 1'b0, 4'b1001};
    vecs[8]  = '{1'b1, 2'b11, 32'h000000F0, 32'h0000000F, 2'b10, 1'b1, 1'b0, 32'h000000FF, 1'b1, 4'b0001};
    vecs[9]  = '{1'b1, 2'b00, 32'hFFFFFFFF, 32'h00000001, 2'b01, 1'b1, 1'b0, 32'h00000000, 1'b1, 4'b0010};
    vecs[10] = '{1'b1, 2'b00, 32'h00000003, 32'h00000004, 2'b11, 1'b1, 1'b1, 32'h00000000, 1'b1, 4'b0010};
    vecs[11] = '{1'b1, 2'b01, 32'h80000000, 32'h00000001, 2'b11, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 4'b0011};
    vecs[12] = '{1'b0, 2'b00, 32'h0,        32'h0,        2'b11, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 4'b0011};
    vecs[13] = '{1'b0, 2'b00, 32'h0,        32'h0,        2'b11, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 4'b0011};

    reset = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("reset.result", ALUResult, 32'h0);
    check("reset.valid", {31'd0, ResultValid}, 32'h0);
    check("reset.flags", {28'd0, Flags}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].fw, vecs[i].ce,
            vecs[i].st);
      step($sformatf("vec%0d", i), vecs[i].res, vecs[i].rv, vecs[i].fl);
    end

    // Three stalled cycles with a pending ADD, then exactly one update on release.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b00, 32'd1, 32'd1, 2'b11, 1'b1, 1'b1);
      step($sformatf("stall%0d", k), 32'h7FFFFFFF, 1'b0, 4'b0011);
    end
    drive(1'b1, 2'b00, 32'd1, 32'd1, 2'b11, 1'b1, 1'b0);
    step("stall_release", 32'd2, 1'b1, 4'b0000);
    drive(1'b0, 2'b00, 32'd1, 32'd1, 2'b11, 1'b1, 1'b0);
    step("stall_after", 32'd2, 1'b0, 4'b0000);

    // Async reset between edges while an ADD is in flight.
    drive(1'b1, 2'b00, 32'h7FFFFFFF, 32'h1, 2'b11, 1'b1, 1'b0);
    step("pre_reset", 32'h80000000, 1'b1, 4'b1001);
    drive(1'b1, 2'b00, 32'd2, 32'd3, 2'b11, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset.result", ALUResult, 32'h0);
    check("async_reset.valid", {31'd0, ResultValid}, 32'h0);
    check("async_reset.flags", {28'd0, Flags}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'd2, 32'd3, 2'b11, 1'b1, 1'b0);
    step("post_reset_idle", 32'h0, 1'b0, 4'b0000);
    drive(1'b1, 2'b00, 32'd2, 32'd3, 2'b11, 1'b1, 1'b0);
    step("post_reset_add", 32'd5, 1'b1, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port ALUValid, input, 1 bit: SrcA/SrcB/ALUControl/FlagW/CondEx are valid this cycle.
REQ-005 The block SHALL have port ALUControl, input, 2 bits: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-006 The block SHALL have ports SrcA and SrcB, input, WIDTH bits each: operands.
REQ-007 The block SHALL have port FlagW, input, 2 bits: [1] enables the N/Z update, [0] enables the C/V update.
REQ-008 The block SHALL have port CondEx, input, 1 bit: the issuing instruction's condition passed; 0 suppresses all flag writes.
REQ-009 The block SHALL have port Stall, input, 1 bit: freezes all registers.
REQ-010 The block SHALL have port ALUResult, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port ResultValid, output, 1 bit: ALUResult holds a new result this cycle.
REQ-012 The block SHALL have port Flags, output, 4 bits: registered {N,Z,C,V}, bit 3 = N, bit 0 = V; feeds the condition checker.
REQ-013 The block SHALL have port FlagsNext, output, 4 bits: flags as seen by the next instruction (see Configuration).

Function
REQ-014 ADD SHALL compute SrcA+SrcB; SUB SHALL compute SrcA+~SrcB+1; sums SHALL be WIDTH+1 bits, with the MSB as carry-out.
REQ-015 Computed flags SHALL be: N = result[WIDTH-1]; Z = (result == 0); C = carry-out (SUB: 1 = no borrow); V = (A[msb] == Bop[msb]) & (result[msb] != A[msb]), where Bop is the post-inversion operand.
REQ-016 AND/ORR SHALL produce the bitwise result; computed C and V SHALL be ignored, so C/V stay unchanged even when FlagW[0] = 1.
REQ-017 Latency SHALL be 1 cycle: an edge with ALUValid=1 and Stall=0 loads ALUResult and sets ResultValid=1 for exactly the following cycle.
REQ-018 ResultValid SHALL drop to 0 on any edge with ALUValid=0 and Stall=0; ALUResult SHALL hold its last value.
REQ-019 The N/Z register SHALL update on an edge only when ALUValid & CondEx & FlagW[1] & ~Stall.
REQ-020 The C/V register SHALL update on an edge only when ALUValid & CondEx & FlagW[0] & arithmetic op & ~Stall.
REQ-021 With CondEx=0, ALUResult and ResultValid SHALL still update; Flags SHALL not.
REQ-022 With Stall=1, all registers SHALL hold regardless of ALUValid; upstream holds its inputs and no transaction is lost or duplicated.
REQ-023 Back-to-back ALUValid cycles SHALL each update; the second instruction's CondEx is evaluated by the external checker against FlagsNext.

Reset
REQ-024 While reset=1 (asynchronous): ALUResult = 0, ResultValid = 0, Flags = 4'b0000.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight result; the first post-release edge SHALL behave as an ordinary cycle.

Configuration
REQ-026 Macro FLAG_BYPASS_EN defined: FlagsNext SHALL be combinational, equal to the value Flags will take at the next edge (per REQ-019..022), for same-cycle forwarding to the condition checker.
REQ-027 Macro FLAG_BYPASS_EN undefined: FlagsNext SHALL equal Flags; the pipeline inserts the dependency bubble externally.

Verification (WIDTH=32, CondEx=1, FlagW=11, Stall=0 unless stated)
REQ-028 ADD 0x7FFFFFFF + 0x00000001 -> next cycle ALUResult=0x80000000, ResultValid=1, Flags=1001.
REQ-029 SUB 5 - 5 -> ALUResult=0, Flags=0110; then SUB 3 - 5 -> ALUResult=0xFFFFFFFE, Flags=1000.
REQ-030 Flags=0110, then AND 0xF0 & 0x0F with FlagW=11 -> Flags=0110 (Z set, C retained, V retained, N=0); then same with CondEx=0 after ADD setting Flags=1001 -> Flags remain 1001, ALUResult=0.
REQ-031 Stall=1 for 3 cycles with ALUValid=1 -> outputs frozen; on Stall release, exactly one update.
REQ-032 Assert reset asynchronously between edges during an ADD -> outputs zero immediately; post-release ResultValid=0 until the next ALUValid.
REQ-033 FLAG_BYPASS_EN defined, SUB 5 - 5 with ALUValid=1 -> FlagsNext=0110 in the same cycle; undefined -> FlagsNext tracks Flags.
